// File: rtl/branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : branch_seq_ctrl
//  Description : Branch sequencing controller. Resolves conditional branches
//                in EX, handles delay-slot nullification, requests fetch
//                redirects and keeps saturating branch statistics.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_seq_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             ex_valid,
    input  logic             ex_branch,
    input  logic             ex_jump,
    input  logic             ex_nullify,
    input  logic             ex_backward,
    input  logic [PC_W-1:0]  ex_target,
    input  logic             redirect_ack,
    output logic             redirect_valid,
    output logic [PC_W-1:0]  redirect_pc,
    output logic             flush_id,
    output logic             flush_if,
    output logic             busy,
    output logic             slot_br_err,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] resolved_cnt
);

    // IDLE: waiting for a branch; SLOT: taken branch, delay slot still in ID;
    // REDIRECT: asking fetch to restart at the latched target.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SLOT     = 2'd1,
        ST_REDIRECT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [PC_W-1:0]  target_q, target_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic             flush_if_q, flush_if_d;
    logic             busy_q, busy_d;
    logic             slot_br_err_q, slot_br_err_d;
    logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;
    logic [CNT_W-1:0] resolved_cnt_q, resolved_cnt_d;

    logic             w_br_live;
    logic             w_resolve;
    logic             w_nullify;

    // A branch is only "live" when EX actually advances this cycle.
    assign w_br_live = ex_valid & ex_branch & ~stall;
    // Only a live branch seen while idle is a real resolution; anything seen
    // in SLOT is a delay-slot branch and anything in REDIRECT is wrong-path.
    assign w_resolve = w_br_live & (state_q == ST_IDLE);
    // Forward-taken or backward-not-taken kills the delay slot when n=1.
    assign w_nullify = ex_nullify & (ex_jump ? ~ex_backward : ex_backward);

    // Next-state, target latch, error flag and statistics computation.
    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        slot_br_err_d  = slot_br_err_q;
        taken_cnt_d    = taken_cnt_q;
        resolved_cnt_d = resolved_cnt_q;

        case (state_q)
            ST_IDLE: begin
                // redirect_ack is deliberately ignored here.
                if (w_resolve && ex_jump) begin
                    target_d = ex_target;
                    // A nullified slot needs no SLOT wait: go straight to redirect.
                    state_d  = w_nullify ? ST_REDIRECT : ST_SLOT;
                end
            end
            ST_SLOT: begin
                if (w_br_live) begin
                    slot_br_err_d = 1'b1;
                end
                // The slot leaves ID on the first unstalled cycle.
                if (!stall) begin
                    state_d = ST_REDIRECT;
                end
            end
            ST_REDIRECT: begin
                // Acknowledge is honoured regardless of stall.
                if (redirect_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Saturating statistics: hold at all-ones instead of wrapping.
        if (w_resolve && !(&resolved_cnt_q)) begin
            resolved_cnt_d = resolved_cnt_q + CNT_W'(1);
        end
        if (w_resolve && ex_jump && !(&taken_cnt_q)) begin
            taken_cnt_d = taken_cnt_q + CNT_W'(1);
        end
    end

    // Registered outputs are decoded from the next state so they line up with
    // the state register.
    always_comb begin
        redirect_valid_d = (state_d == ST_REDIRECT);
        flush_if_d       = (state_d == ST_REDIRECT);
        busy_d           = (state_d != ST_IDLE);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            target_q         <= '0;
            redirect_valid_q <= 1'b0;
            flush_if_q       <= 1'b0;
            busy_q           <= 1'b0;
            slot_br_err_q    <= 1'b0;
            taken_cnt_q      <= '0;
            resolved_cnt_q   <= '0;
        end else begin
            state_q          <= state_d;
            target_q         <= target_d;
            redirect_valid_q <= redirect_valid_d;
            flush_if_q       <= flush_if_d;
            busy_q           <= busy_d;
            slot_br_err_q    <= slot_br_err_d;
            taken_cnt_q      <= taken_cnt_d;
            resolved_cnt_q   <= resolved_cnt_d;
        end
    end

    // flush_id acts in the resolve cycle itself, so it is combinational; it is
    // gated by rst_n so that reset silences it immediately.
    assign flush_id       = rst_n & w_resolve & w_nullify;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = target_q;
    assign flush_if       = flush_if_q;
    assign busy           = busy_q;
    assign slot_br_err    = slot_br_err_q;
    assign taken_cnt      = taken_cnt_q;
    assign resolved_cnt   = resolved_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_seq_ctrl
//  Description : Self-checking bench for branch_seq_ctrl. Directed scenarios
//                plus randomized traffic against a behavioural model. A second
//                instance with narrow counters exercises saturation quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_seq_ctrl;

    localparam int PC_W  = 32;
    localparam int CNT_W = 16;
    localparam int SAT_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n = 1'b0;
    logic             stall = 1'b0;
    logic             ex_valid = 1'b0;
    logic             ex_branch = 1'b0;
    logic             ex_jump = 1'b0;
    logic             ex_nullify = 1'b0;
    logic             ex_backward = 1'b0;
    logic [PC_W-1:0]  ex_target = '0;
    logic             redirect_ack = 1'b0;

    logic             redirect_valid, flush_id, flush_if, busy, slot_br_err;
    logic [PC_W-1:0]  redirect_pc;
    logic [CNT_W-1:0] taken_cnt, resolved_cnt;

    logic             s_redirect_valid, s_flush_id, s_flush_if, s_busy, s_slot_br_err;
    logic [PC_W-1:0]  s_redirect_pc;
    logic [SAT_W-1:0] s_taken_cnt, s_resolved_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: mode 0 idle, 1 waiting for delay slot, 2 redirecting.
    int              m_mode;
    logic [PC_W-1:0] m_pc;
    logic            m_err;
    int              m_taken;
    int              m_resolved;

    branch_seq_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_nullify(ex_nullify),
        .ex_backward(ex_backward), .ex_target(ex_target),
        .redirect_ack(redirect_ack), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .flush_id(flush_id), .flush_if(flush_if),
        .busy(busy), .slot_br_err(slot_br_err), .taken_cnt(taken_cnt),
        .resolved_cnt(resolved_cnt)
    );

    branch_seq_ctrl #(.PC_W(PC_W), .CNT_W(SAT_W)) dut_sat (
        .clk(clk), .rst_n(rst_n), .stall(stall), .ex_valid(ex_valid),
        .ex_branch(ex_branch), .ex_jump(ex_jump), .ex_nullify(ex_nullify),
        .ex_backward(ex_backward), .ex_target(ex_target),
        .redirect_ack(redirect_ack), .redirect_valid(s_redirect_valid),
        .redirect_pc(s_redirect_pc), .flush_id(s_flush_id), .flush_if(s_flush_if),
        .busy(s_busy), .slot_br_err(s_slot_br_err), .taken_cnt(s_taken_cnt),
        .resolved_cnt(s_resolved_cnt)
    );

    function automatic int sat(input int v, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (v > mx) ? mx : v;
    endfunction

    task automatic set_idle();
        ex_valid = 0; ex_branch = 0; ex_jump = 0; ex_nullify = 0;
        ex_backward = 0; stall = 0; redirect_ack = 0; ex_target = '0;
    endtask

    task automatic drive_branch(input logic j, input logic n, input logic back,
                                input logic [PC_W-1:0] tgt);
        ex_valid = 1; ex_branch = 1; ex_jump = j; ex_nullify = n;
        ex_backward = back; ex_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        set_idle();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1;
        m_mode = 0; m_pc = '0; m_err = 0; m_taken = 0; m_resolved = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit live, kill;
        live = ex_valid && ex_branch && !stall;
        kill = ex_nullify && ((ex_jump && !ex_backward) || (!ex_jump && ex_backward));
        if (m_mode == 0) begin
            if (live) begin
                m_resolved++;
                if (ex_jump) begin
                    m_taken++;
                    m_pc   = ex_target;
                    m_mode = kill ? 2 : 1;
                end
            end
        end else if (m_mode == 1) begin
            if (live) m_err = 1;
            if (!stall) m_mode = 2;
        end else begin
            if (redirect_ack) m_mode = 0;
        end
    endtask

    task automatic test_reset();
        set_idle();
        rst_n = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({redirect_valid, flush_id, flush_if, busy, slot_br_err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b exp 00000",
                     {redirect_valid, flush_id, flush_if, busy, slot_br_err});
        end
        n_checks++;
        if ({redirect_pc, taken_cnt, resolved_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_data pc=%h taken=%h resolved=%h exp all 0",
                     redirect_pc, taken_cnt, resolved_cnt);
        end
    endtask

    task automatic test_taken_slot();
        apply_reset();
        drive_branch(1, 0, 0, 32'h0000_0100);
        redirect_ack = 1;                  // ack in IDLE must be ignored
        @(negedge clk);
        n_checks++;
        if ({flush_id, flush_if, redirect_valid, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL slot_c0 got %b exp 0000", {flush_id, flush_if, redirect_valid, busy});
        end
        tick();
        set_idle();
        @(negedge clk);
        n_checks++;
        if ({flush_id, flush_if, redirect_valid, busy} !== 4'b0001) begin
            n_fail++;
            $display("FAIL slot_c1 got %b exp 0001", {flush_id, flush_if, redirect_valid, busy});
        end
        tick();
        redirect_ack = 1;
        @(negedge clk);
        n_checks++;
        if ({flush_if, redirect_valid, busy} !== 3'b111 || redirect_pc !== 32'h100) begin
            n_fail++;
            $display("FAIL slot_c2 got %b pc=%h exp 111 pc=00000100",
                     {flush_if, redirect_valid, busy}, redirect_pc);
        end
        tick();
        redirect_ack = 0;
        @(negedge clk);
        n_checks++;
        if ({flush_if, redirect_valid, busy} !== 3'b000 || taken_cnt !== 16'd1
            || resolved_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL slot_c3 got %b taken=%0d resolved=%0d exp 000 1 1",
                     {flush_if, redirect_valid, busy}, taken_cnt, resolved_cnt);
        end
    endtask

    task automatic test_taken_nullify();
        apply_reset();
        drive_branch(1, 1, 0, 32'h0000_0040);
        @(negedge clk);
        n_checks++;
        if (flush_id !== 1'b1 || flush_if !== 1'b0) begin
            n_fail++;
            $display("FAIL null_c0 flush_id=%b flush_if=%b exp 1 0", flush_id, flush_if);
        end
        tick();
        set_idle();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) redirect_ack = 1;
            @(negedge clk);
            n_checks++;
            if ({redirect_valid, flush_if, flush_id} !== 3'b110 || redirect_pc !== 32'h40) begin
                n_fail++;
                $display("FAIL null_hold%0d got %b pc=%h exp 110 pc=00000040",
                         i, {redirect_valid, flush_if, flush_id}, redirect_pc);
            end
            tick();
        end
        redirect_ack = 0;
        @(negedge clk);
        n_checks++;
        if ({redirect_valid, busy} !== 2'b00 || redirect_pc !== 32'h40) begin
            n_fail++;
            $display("FAIL null_after got %b pc=%h exp 00 pc=00000040",
                     {redirect_valid, busy}, redirect_pc);
        end
    endtask

    task automatic test_not_taken_null();
        apply_reset();
        drive_branch(0, 1, 1, 32'h0000_0800);
        @(negedge clk);
        n_checks++;
        if (flush_id !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ntn_c0 flush_id=%b busy=%b exp 1 0", flush_id, busy);
        end
        tick();
        set_idle();
        @(negedge clk);
        n_checks++;
        if ({flush_id, busy, redirect_valid} !== 3'b000 || taken_cnt !== 16'd0
            || resolved_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL ntn_c1 got %b taken=%0d resolved=%0d exp 000 0 1",
                     {flush_id, busy, redirect_valid}, taken_cnt, resolved_cnt);
        end
    endtask

    task automatic test_slot_stall();
        apply_reset();
        drive_branch(1, 0, 0, 32'h0000_0200);
        tick();
        set_idle();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if ({busy, redirect_valid} !== 2'b10) begin
                n_fail++;
                $display("FAIL stall_slot%0d got %b exp 10", i, {busy, redirect_valid});
            end
            tick();
        end
        stall = 0;
        drive_branch(1, 1, 0, 32'h0000_0DEA);   // branch sitting in the delay slot
        @(negedge clk);
        n_checks++;
        if ({flush_id, slot_br_err, redirect_valid} !== 3'b000) begin
            n_fail++;
            $display("FAIL slotbr_c0 got %b exp 000", {flush_id, slot_br_err, redirect_valid});
        end
        tick();
        drive_branch(1, 0, 0, 32'h0000_0999);   // wrong-path branch during REDIRECT
        redirect_ack = 1;
        @(negedge clk);
        n_checks++;
        if ({slot_br_err, redirect_valid} !== 2'b11 || redirect_pc !== 32'h200
            || taken_cnt !== 16'd1 || resolved_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL slotbr_c1 got %b pc=%h taken=%0d resolved=%0d exp 11 00000200 1 1",
                     {slot_br_err, redirect_valid}, redirect_pc, taken_cnt, resolved_cnt);
        end
        tick();
        set_idle();
        @(negedge clk);
        n_checks++;
        if ({slot_br_err, busy} !== 2'b10 || redirect_pc !== 32'h200
            || taken_cnt !== 16'd1 || resolved_cnt !== 16'd1) begin
            n_fail++;
            $display("FAIL redir_br got %b pc=%h taken=%0d resolved=%0d exp 10 00000200 1 1",
                     {slot_br_err, busy}, redirect_pc, taken_cnt, resolved_cnt);
        end
    endtask

    task automatic test_random();
        logic e_fid;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            ex_valid     = ($urandom_range(0, 3) != 0);
            ex_branch    = $urandom_range(0, 1);
            ex_jump      = $urandom_range(0, 1);
            ex_nullify   = $urandom_range(0, 1);
            ex_backward  = $urandom_range(0, 1);
            stall        = ($urandom_range(0, 3) == 0);
            redirect_ack = $urandom_range(0, 1);
            ex_target    = $urandom();
            @(negedge clk);
            e_fid = (m_mode == 0) && ex_valid && ex_branch && !stall && ex_nullify
                    && ((ex_jump && !ex_backward) || (!ex_jump && ex_backward));
            n_checks++;
            if ({flush_id, flush_if, redirect_valid, busy, slot_br_err} !==
                {e_fid, m_mode == 2, m_mode == 2, m_mode != 0, m_err}) begin
                n_fail++;
                $display("FAIL rnd_ctrl cyc%0d got %b exp %b", i,
                         {flush_id, flush_if, redirect_valid, busy, slot_br_err},
                         {e_fid, m_mode == 2, m_mode == 2, m_mode != 0, m_err});
            end
            n_checks++;
            if (redirect_pc !== m_pc || s_redirect_pc !== m_pc) begin
                n_fail++;
                $display("FAIL rnd_pc cyc%0d got %h/%h exp %h", i, redirect_pc, s_redirect_pc, m_pc);
            end
            n_checks++;
            if (taken_cnt !== CNT_W'(sat(m_taken, CNT_W))
                || resolved_cnt !== CNT_W'(sat(m_resolved, CNT_W))
                || s_taken_cnt !== SAT_W'(sat(m_taken, SAT_W))
                || s_resolved_cnt !== SAT_W'(sat(m_resolved, SAT_W))) begin
                n_fail++;
                $display("FAIL rnd_cnt cyc%0d got %0d/%0d sat %0d/%0d exp raw %0d/%0d",
                         i, taken_cnt, resolved_cnt, s_taken_cnt, s_resolved_cnt,
                         m_taken, m_resolved);
            end
            @(posedge clk);
            model_step();
            #1;
        end
        set_idle();
    endtask

    task automatic test_saturation();
        apply_reset();
        for (int i = 0; i < 257; i++) begin
            drive_branch(1, 1, 0, PC_W'(i));
            tick();
            set_idle();
            redirect_ack = 1;
            tick();
            redirect_ack = 0;
            if (i == 253) begin
                @(negedge clk);
                n_checks++;
                if (s_taken_cnt !== 8'hFE || s_resolved_cnt !== 8'hFE) begin
                    n_fail++;
                    $display("FAIL sat_pre got %h/%h exp FE/FE", s_taken_cnt, s_resolved_cnt);
                end
                tick();
            end
        end
        @(negedge clk);
        n_checks++;
        if (s_taken_cnt !== 8'hFF || s_resolved_cnt !== 8'hFF
            || taken_cnt !== 16'd257 || resolved_cnt !== 16'd257) begin
            n_fail++;
            $display("FAIL sat_full got sat %h/%h wide %0d/%0d exp FF/FF 257/257",
                     s_taken_cnt, s_resolved_cnt, taken_cnt, resolved_cnt);
        end
        tick();
        drive_branch(1, 1, 0, 32'h0000_0ABC);
        tick();
        // Now in REDIRECT; keep a resolving pattern on the inputs while reset hits.
        drive_branch(0, 1, 1, 32'h0000_0123);
        #2;
        n_checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'hABC) begin
            n_fail++;
            $display("FAIL sat_redir got rv=%b pc=%h exp 1 00000ABC", redirect_valid, redirect_pc);
        end
        rst_n = 0;
        #1;
        n_checks++;
        if ({redirect_valid, flush_id, flush_if, busy, slot_br_err} !== 5'b0
            || redirect_pc !== '0 || taken_cnt !== '0 || resolved_cnt !== '0
            || s_taken_cnt !== '0 || s_resolved_cnt !== '0 || s_redirect_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst got ctrl %b pc=%h cnt %0d/%0d sat %0d/%0d exp all 0",
                     {redirect_valid, flush_id, flush_if, busy, slot_br_err}, redirect_pc,
                     taken_cnt, resolved_cnt, s_taken_cnt, s_resolved_cnt);
        end
        set_idle();
        tick();
        rst_n = 1;
    endtask

    initial begin
        test_reset();
        test_taken_slot();
        test_taken_nullify();
        test_not_taken_null();
        test_slot_stall();
        test_random();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_seq_ctrl.md
BRANCH_SEQ_CTRL -- requirements
Module: branch_seq_ctrl

Interface
REQ-001 SHALL have parameter PC_W, default 32, program-counter/target width.
REQ-002 SHALL have parameter CNT_W, default 16, statistics counter width.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset; asynchronous, active-low.
REQ-005 stall  in  1  pipeline stall from hazard unit; EX/ID contents held this cycle.
REQ-006 ex_valid  in  1  EX stage holds a live (non-nullified) instruction.
REQ-007 ex_branch  in  1  EX instruction is a conditional branch (condition handler B input).
REQ-008 ex_jump  in  1  branch decision J from condition handler.
REQ-009 ex_nullify  in  1  instruction n-bit.
REQ-010 ex_backward  in  1  branch displacement negative.
REQ-011 ex_target  in  PC_W  computed branch target.
REQ-012 redirect_ack  in  1  fetch unit accepted redirect this cycle.
REQ-013 redirect_valid  out  1  fetch redirect request.
REQ-014 redirect_pc  out  PC_W  redirect address, stable while redirect_valid.
REQ-015 flush_id  out  1  kill instruction in ID (delay slot) this cycle.
REQ-016 flush_if  out  1  kill instruction in IF this cycle.
REQ-017 busy  out  1  state != IDLE.
REQ-018 slot_br_err  out  1  sticky: branch seen in delay slot.
REQ-019 taken_cnt  out  CNT_W  taken-branch count.
REQ-020 resolved_cnt  out  CNT_W  resolved-branch count.

Function
REQ-021 Resolve event SHALL be ex_valid & ex_branch & ~stall & state==IDLE; nothing else counts as resolution.
REQ-022 Slot nullification SHALL be ex_nullify & (ex_jump ? ~ex_backward : ex_backward) (forward-taken or backward-not-taken nullifies).
REQ-023 States SHALL be IDLE, SLOT, REDIRECT; encoding free.
REQ-024 IDLE, resolve, ex_jump=1, nullify=0: latch ex_target, next state SLOT, no flush.
REQ-025 IDLE, resolve, ex_jump=1, nullify=1: latch ex_target, flush_id=1 same cycle (combinational), next state REDIRECT.
REQ-026 IDLE, resolve, ex_jump=0, nullify=1: flush_id=1 same cycle, stay IDLE.
REQ-027 IDLE, resolve, ex_jump=0, nullify=0: no output action, stay IDLE.
REQ-028 SLOT: hold while stall=1; first cycle with stall=0 (delay slot leaves ID) -> REDIRECT.
REQ-029 REDIRECT: redirect_valid=1, flush_if=1 every cycle, redirect_pc=latched target; redirect_ack=1 -> IDLE next edge; stall SHALL NOT block ack.
REQ-030 redirect_pc SHALL hold last latched target when redirect_valid=0; reset value 0.
REQ-031 ex_valid & ex_branch & ~stall while state==SLOT SHALL be ignored for control and set slot_br_err=1 (sticky until reset).
REQ-032 Branch in EX while REDIRECT SHALL be ignored (wrong path, being flushed); no counter change.
REQ-033 resolved_cnt +1 per resolve event; taken_cnt +1 per resolve event with ex_jump=1; both saturate at all-ones, no wrap.
REQ-034 Resolve event with redirect_ack in IDLE: ack ignored.
REQ-035 flush_id and flush_if SHALL be 0 in all cases not listed above.

Reset
REQ-036 rst_n=0 SHALL immediately force state IDLE, redirect_valid=0, flush_id=0, flush_if=0, busy=0, slot_br_err=0, counters=0, redirect_pc=0, from any state incl. mid-REDIRECT.
REQ-037 First resolve event SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-038 Taken forward, n=0, target 0x0000_0100, no stall -> cycle0 no flush; cycle1 SLOT; cycle2 redirect_valid=1 pc=0x100 flush_if=1; ack cycle2 -> IDLE cycle3; taken_cnt=1, resolved_cnt=1.
REQ-039 Taken forward, n=1, target 0x40 -> flush_id=1 in resolve cycle, REDIRECT next cycle, redirect_pc=0x40 held 3 cycles until ack.
REQ-040 Not taken, backward, n=1 -> flush_id=1 one cycle, busy stays 0, taken_cnt=0, resolved_cnt=1.
REQ-041 Taken n=0, stall=1 for 3 cycles in SLOT -> stays SLOT 3 cycles; branch presented in SLOT with stall=0 -> slot_br_err=1, counters unchanged by it.
REQ-042 Preload counters to 0xFFFE via 2^16-2 taken branches, apply 3 more -> both counters 0xFFFF; rst_n low mid-REDIRECT -> redirect_valid=0 and counters=0 without clock edge.
